sysbus_arbiter: RTL



---
 rtl/sysbus_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbiter for the shared system bus, with a one-cycle turnaround between owners.
// Optional busy-hold watchdog is built when SYSBUS_ARB_WDOG_EN is defined.
module sysbus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OWNER_WIDTH = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic [OWNER_WIDTH-1:0] owner,
  output logic                   owner_vld,
  output logic                   wdog_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]             state;
  logic [OWNER_WIDTH-1:0] last;
  logic [OWNER_WIDTH-1:0] pick;
  logic [OWNER_WIDTH-1:0] cand;
  logic                   pick_vld;
  logic [NUM_REQ-1:0]     busy_eff;
  logic                   wdog_hit;

  // Scan from the farthest candidate down to last+1 so the nearest set request is written last and wins.
  // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = OWNER_WIDTH'((int'(last) + i) % NUM_REQ);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef SYSBUS_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0]      wdog_cnt;
  logic [NUM_REQ-1:0] wdog_mask;

  // A revoked requester's busy stays masked until it finally lets go of the bus.
  assign busy_eff = busy & ~wdog_mask;
  assign wdog_hit = (state == S_BUSY) && busy[owner] && (wdog_cnt == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt  <= '0;
      wdog_mask <= '0;
      wdog_err  <= 1'b0;
    end else begin
      wdog_err  <= wdog_hit;
      wdog_mask <= (wdog_mask & busy) | (wdog_hit ? grant : '0);
      if (state == S_GRANT && busy_eff[owner]) begin
        wdog_cnt <= '0;
      end else if (state == S_BUSY) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
    end
  end
`else
  assign busy_eff = busy;
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      grant <= '0;
      owner <= '0;
      last  <= OWNER_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (busy_eff[owner]) begin
            state <= S_BUSY;
          end else if (!req[owner]) begin
            grant <= '0;
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (!busy[owner] || wdog_hit) begin
            grant <= '0;
            last  <= owner;
            state <= S_RELEASE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign owner_vld = |grant;

endmodule
